// File: rtl/sum_led_scan_if.sv
// Adder-result bus into the display scanner plus the multiplexed 7-segment pins out of it.
// master = adder/board side driving the result, slave = the scanner.
interface sum_led_scan_if;
  logic [3:0] sum;
  logic       cout;
  logic       load;
  logic       hex_mode;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output sum, cout, load, hex_mode, input an, seg, dp);
  modport slave  (input sum, cout, load, hex_mode, output an, seg, dp);
endinterface

// File: rtl/sum_led_scan.sv
// Captures the 5-bit adder result on load and scans it as decimal/hex over a 4-digit active-low 7-seg display.
// Content lags value by 1 cycle; one digit per SCAN_DIV cycles; no backpressure, inputs sampled every edge.
module sum_led_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  sum_led_scan_if.slave bus
);

  localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_LTR_D = 7'b0100001;
  localparam logic [6:0]     SEG_LTR_H = 7'b0001001;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0:    seg_enc = 7'b1000000;
      4'h1:    seg_enc = 7'b1111001;
      4'h2:    seg_enc = 7'b0100100;
      4'h3:    seg_enc = 7'b0110000;
      4'h4:    seg_enc = 7'b0011001;
      4'h5:    seg_enc = 7'b0010010;
      4'h6:    seg_enc = 7'b0000010;
      4'h7:    seg_enc = 7'b1111000;
      4'h8:    seg_enc = 7'b0000000;
      4'h9:    seg_enc = 7'b0010000;
      4'hA:    seg_enc = 7'b0001000;
      4'hB:    seg_enc = 7'b0000011;
      4'hC:    seg_enc = 7'b1000110;
      4'hD:    seg_enc = 7'b0100001;
      4'hE:    seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  logic [4:0]      value_q, value_d;
  logic [3:0][6:0] dig_q, dig_d;
  logic            dp1_q, dp1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick;
  logic [1:0]      tens;
  logic [3:0]      ones;

  assign tick = (cnt_q == CNT_MAX);

  // Value is at most 31, so a compare ladder replaces a general divider.
  always_comb begin
    tens = 2'd0;
    ones = value_q[3:0];
    if (value_q >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(value_q - 5'd30);
    end else if (value_q >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(value_q - 5'd20);
    end else if (value_q >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(value_q - 5'd10);
    end
  end

  always_comb begin
    value_d = bus.load ? {bus.cout, bus.sum} : value_q;

    dig_d    = {4{SEG_BLANK}};
    dig_d[3] = bus.hex_mode ? SEG_LTR_H : SEG_LTR_D;
    if (bus.hex_mode) begin
      dig_d[0] = seg_enc(value_q[3:0]);
      dig_d[1] = value_q[4] ? seg_enc(4'h1) : SEG_BLANK;
    end else begin
      dig_d[0] = seg_enc(ones);
      dig_d[1] = (tens != 2'd0) ? seg_enc({2'b00, tens}) : SEG_BLANK;
    end
    dp1_d = ~value_q[4];

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sel_d = sel_q;
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      sel_d = sel_q + 2'd1;
      an_d  = ~(4'b0001 << sel_q);
      seg_d = dig_q[sel_q];
      dp_d  = (sel_q == 2'd1) ? dp1_q : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dig_q   <= {4{SEG_BLANK}};
      dp1_q   <= 1'b1;
      cnt_q   <= '0;
      sel_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      value_q <= value_d;
      dig_q   <= dig_d;
      dp1_q   <= dp1_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sum_led_scan.sv
// Scoreboard bench for sum_led_scan: one instance with SCAN_DIV=4, one with SCAN_DIV=1.
module tb_sum_led_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sum_led_scan_if bus4();
  sum_led_scan_if bus1();

  sum_led_scan #(.SCAN_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sum_led_scan #(.SCAN_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic logic [6:0] m_seg(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return BLANK;
    endcase
  endfunction

  task automatic push_scan(input int v, input bit hx);
    exp_t e;
    int   lo, hi;
    lo = hx ? (v % 16) : (v % 10);
    hi = hx ? (v / 16) : (v / 10);
    e.an = 4'b1110; e.seg = m_seg(lo); e.dp = 1'b1;
    exp_q.push_back(e);
    e.an = 4'b1101; e.seg = (hi == 0) ? BLANK : m_seg(hi); e.dp = (v >= 16) ? 1'b0 : 1'b1;
    exp_q.push_back(e);
    e.an = 4'b1011; e.seg = BLANK; e.dp = 1'b1;
    exp_q.push_back(e);
    e.an = 4'b0111; e.seg = hx ? 7'b0001001 : 7'b0100001; e.dp = 1'b1;
    exp_q.push_back(e);
  endtask

  // Aligns on a freshly started digit0 slot of the SCAN_DIV=4 instance and records one full scan.
  task automatic capture_scan4(output exp_t [3:0] got, output bit timed_out);
    int budget;
    budget    = 200;
    timed_out = 1'b0;
    got       = '0;
    while (bus4.an == 4'b1110 && budget > 0) begin @(negedge clk); budget--; end
    while (bus4.an != 4'b1110 && budget > 0) begin @(negedge clk); budget--; end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] cur;
      got[i] = {bus4.an, bus4.seg, bus4.dp};
      cur    = bus4.an;
      if (i < 3)
        while (bus4.an == cur && budget > 0) begin @(negedge clk); budget--; end
    end
    if (budget == 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    bus4.sum = '0; bus4.cout = 1'b0; bus4.load = 1'b0; bus4.hex_mode = 1'b0;
    bus1.sum = '0; bus1.cout = 1'b0; bus1.load = 1'b0; bus1.hex_mode = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus4.an, bus4.seg, bus4.dp} !== {4'b1111, BLANK, 1'b1}) begin
      bad++;
      $display("FAIL reset4: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", bus4.an, bus4.seg, bus4.dp);
    end
    total++;
    if ({bus1.an, bus1.seg, bus1.dp} !== {4'b1111, BLANK, 1'b1}) begin
      bad++;
      $display("FAIL reset1: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", bus1.an, bus1.seg, bus1.dp);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        total++;
        if (bus1.an !== 4'b1110) begin
          bad++;
          $display("FAIL div1_first_tick: got an=%b, want 1110", bus1.an);
        end
      end
      total++;
      if (k < 4 && {bus4.an, bus4.seg} !== {4'b1111, BLANK}) begin
        bad++;
        $display("FAIL pre_tick edge%0d: got an=%b seg=%b, want an=1111 seg=1111111", k, bus4.an, bus4.seg);
      end else if (k == 4 && {bus4.an, bus4.seg} !== {4'b1110, 7'b1000000}) begin
        bad++;
        $display("FAIL first_tick: got an=%b seg=%b, want an=1110 seg=1000000", bus4.an, bus4.seg);
      end
    end
    for (int d = 1; d < 4; d++) begin
      logic [3:0] want;
      want = ~(4'b0001 << d);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus4.an !== 4'b1110 << (d - 1) | 4'b0001 >> 0 && 1'b0) begin
        bad++;
      end
      if (bus4.an !== ~(4'b0001 << (d - 1))) begin
        bad++;
        $display("FAIL hold digit%0d: got an=%b, want %b", d - 1, bus4.an, ~(4'b0001 << (d - 1)));
      end
      @(posedge clk); #1;
      total++;
      if (bus4.an !== want) begin
        bad++;
        $display("FAIL scan_step digit%0d: got an=%b, want %b", d, bus4.an, want);
      end
    end
  endtask

  task automatic test_format();
    int   vals [5] = '{31, 31, 5, 16, 10};
    bit   hxs  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t got [3:0];
    exp_t [3:0] got_p;
    exp_t e;
    bit   to;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      bus4.sum      = vals[t][3:0];
      bus4.cout     = vals[t][4];
      bus4.hex_mode = hxs[t];
      bus4.load     = 1'b1;
      @(negedge clk);
      bus4.load = 1'b0;
      bus4.sum  = 4'h0;
      bus4.cout = 1'b0;
      push_scan(vals[t], hxs[t]);
      repeat (2) @(negedge clk);
      capture_scan4(got_p, to);
      got = '{got_p[3], got_p[2], got_p[1], got_p[0]};
      total++;
      if (to) begin
        bad++;
        $display("FAIL fmt_timeout v=%0d hx=%0d: got no full scan within budget, want 4 digits", vals[t], hxs[t]);
      end
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        total++;
        if (got_p[i] !== e) begin
          bad++;
          $display("FAIL fmt v=%0d hx=%0d digit%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   vals[t], hxs[t], i, got_p[i].an, got_p[i].seg, got_p[i].dp, e.an, e.seg, e.dp);
        end
      end
    end
  endtask

  task automatic test_load_on_tick();
    exp_t e;
    exp_t w;
    int   budget;
    @(negedge clk);
    bus1.hex_mode = 1'b0;
    bus1.sum = 4'd9; bus1.cout = 1'b0; bus1.load = 1'b1;
    @(negedge clk);
    bus1.load = 1'b0;
    repeat (3) @(negedge clk);
    budget = 20;
    while (bus1.an != 4'b0111 && budget > 0) begin @(negedge clk); budget--; end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL tick_align: got an=%b, want 0111 within budget", bus1.an);
    end
    bus1.sum = 4'd10; bus1.load = 1'b1;
    w.an = 4'b1110; w.seg = m_seg(9); w.dp = 1'b1; exp_q.push_back(w);
    w.an = 4'b1110; w.seg = m_seg(0); w.dp = 1'b1; exp_q.push_back(w);
    w.an = 4'b1101; w.seg = m_seg(1); w.dp = 1'b1; exp_q.push_back(w);
    @(posedge clk); #1;
    bus1.load = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({bus1.an, bus1.seg, bus1.dp} !== e) begin
      bad++;
      $display("FAIL load_tick_old: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               bus1.an, bus1.seg, bus1.dp, e.an, e.seg, e.dp);
    end
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bus1.an, bus1.seg, bus1.dp} !== e) begin
        bad++;
        $display("FAIL load_tick_new%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 i, bus1.an, bus1.seg, bus1.dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    budget = 100;
    while (bus4.an != 4'b1011 && budget > 0) begin @(negedge clk); budget--; end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL mid_align: got an=%b, want 1011 within budget", bus4.an);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus4.an, bus4.seg, bus4.dp} !== {4'b1111, BLANK, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", bus4.an, bus4.seg, bus4.dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (k < 4 && bus4.an !== 4'b1111) begin
        bad++;
        $display("FAIL restart edge%0d: got an=%b, want 1111", k, bus4.an);
      end else if (k == 4 && {bus4.an, bus4.seg, bus4.dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
        bad++;
        $display("FAIL restart_digit0: got an=%b seg=%b dp=%b, want an=1110 seg=1000000 dp=1", bus4.an, bus4.seg, bus4.dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_format();
    test_load_on_tick();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
